// File: rtl/acumulador_producto.sv
`default_nettype none
// ============================================================================
// Module      : acumulador_producto
// Description : Accumulates N_TERMS signed products from the Booth multiplier
//               into one signed group sum. The sum is offered to the next
//               stage through a valid/ready handshake. A 1-deep holding
//               register absorbs one product that arrives while a finished
//               sum is waiting to be taken.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous reset, active low
//               resultado  - signed product from the multiplier
//               fin        - multiplier done (rising edge = one product)
//               clear      - synchronous flush of group, hold reg and flags
//               acc_out    - signed group sum
//               acc_valid  - acc_out holds a completed group
//               acc_ready  - consumer accepts acc_out
//               overflow   - signed overflow in the group on acc_out
//               perdido    - sticky: a product was dropped
//               cuenta     - products in the current group
// Options     : define ACUMULADOR_SATURA_EN to saturate on signed overflow
//               instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module acumulador_producto #(
    parameter int PROD_W  = 6,
    parameter int ACC_W   = 12,
    parameter int N_TERMS = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [PROD_W-1:0]                resultado,
    input  logic                             fin,
    input  logic                             clear,
    output logic [ACC_W-1:0]                 acc_out,
    output logic                             acc_valid,
    input  logic                             acc_ready,
    output logic                             overflow,
    output logic                             perdido,
    output logic [$clog2(N_TERMS+1)-1:0]     cuenta
);

    localparam int CNT_W = $clog2(N_TERMS + 1);

    localparam logic [0:0]       c_ACUM    = 1'b0;
    localparam logic [0:0]       c_ENTREGA = 1'b1;
    localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(N_TERMS - 1);
    localparam logic [CNT_W-1:0] c_FULL    = CNT_W'(N_TERMS);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             r_fin_q;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_hold;
    logic             r_hold_vld;
    logic             r_lost;

    logic             w_ev;
    logic             w_hs;
    logic [ACC_W-1:0] w_p;
    logic [ACC_W:0]   w_add;      // {overflow, sum} for acc + p
    logic [ACC_W:0]   w_hs_add;   // {overflow, sum} for new group on handshake
    logic [CNT_W-1:0] w_hs_cnt;

    // Returns {overflow, sum}. Overflow: operands share a sign, sum differs.
    function automatic logic [ACC_W:0] f_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
        logic [ACC_W-1:0] s;
        logic             ov;
        s  = a + b;
        ov = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
`ifdef ACUMULADOR_SATURA_EN
        if (ov) begin
            s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
        return {ov, s};
    endfunction

    generate
        if (ACC_W > PROD_W) begin : g_ext
            assign w_p = {{(ACC_W-PROD_W){resultado[PROD_W-1]}}, resultado};
        end else begin : g_noext
            assign w_p = resultado;
        end
    endgenerate

    // Only the rising edge of fin is a new product; a held fin counts once.
    assign w_ev  = fin & ~r_fin_q;
    assign w_hs  = acc_valid & acc_ready;
    assign w_add = f_add(r_acc, w_p);

    // The next group is seeded with the held product and/or the product
    // arriving in the handshake cycle itself.
    assign w_hs_add = f_add(r_hold_vld ? r_hold : '0, w_ev ? w_p : '0);
    assign w_hs_cnt = {{(CNT_W-1){1'b0}}, r_hold_vld} + {{(CNT_W-1){1'b0}}, w_ev};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ACUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = c_ACUM;
        end else begin
            case (r_state)
                c_ACUM: begin
                    if (w_ev && (r_cnt == c_LAST)) begin
                        w_state_nxt = c_ENTREGA;
                    end
                end
                c_ENTREGA: begin
                    if (w_hs) begin
                        // With N_TERMS == 2 the seeded group can already be full.
                        w_state_nxt = (w_hs_cnt == c_FULL) ? c_ENTREGA : c_ACUM;
                    end
                end
                default: w_state_nxt = c_ACUM;
            endcase
        end
    end

    always_comb begin
        acc_valid = (r_state == c_ENTREGA);
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fin_q    <= 1'b0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_lost     <= 1'b0;
        end else begin
            r_fin_q <= fin;
            if (clear) begin
                r_acc      <= '0;
                r_ovf      <= 1'b0;
                r_cnt      <= '0;
                r_hold_vld <= 1'b0;
                r_lost     <= 1'b0;
            end else if (r_state == c_ACUM) begin
                if (w_ev) begin
                    r_acc <= w_add[ACC_W-1:0];
                    r_ovf <= r_ovf | w_add[ACC_W];
                    r_cnt <= r_cnt + c_ONE;
                end
            end else begin
                if (w_hs) begin
                    r_acc      <= w_hs_add[ACC_W-1:0];
                    r_ovf      <= w_hs_add[ACC_W];
                    r_cnt      <= w_hs_cnt;
                    r_hold_vld <= 1'b0;
                end else if (w_ev) begin
                    if (!r_hold_vld) begin
                        r_hold     <= w_p;
                        r_hold_vld <= 1'b1;
                    end else begin
                        r_lost <= 1'b1;
                    end
                end
            end
        end
    end

    assign acc_out  = r_acc;
    assign overflow = r_ovf;
    assign perdido  = r_lost;
    assign cuenta   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_acumulador_producto.sv
`default_nettype none
// ============================================================================
// Module      : tb_acumulador_producto
// Description : Self-checking bench for acumulador_producto. One instance
//               with default widths and one with ACC_W=7 for overflow.
//               Completed group sums are queued when the products are driven
//               and popped when acc_valid is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acumulador_producto;

    logic        clk = 1'b0;
    logic        reset, fin, fin1, clear, acc_ready;
    logic [5:0]  resultado;

    logic [11:0] acc_out;
    logic        acc_valid, overflow, perdido;
    logic [2:0]  cuenta;

    logic [6:0]  acc_out1;
    logic        acc_valid1, overflow1, perdido1;
    logic [2:0]  cuenta1;

    int          n_cmp = 0;
    int          n_bad = 0;

    logic [12:0] q0[$];   // {overflow, acc_out} for the default instance
    logic [7:0]  q1[$];   // {overflow, acc_out} for the ACC_W=7 instance
    logic [12:0] e0;
    logic [7:0]  e1;

    always #5 clk = ~clk;

    acumulador_producto #(.PROD_W(6), .ACC_W(12), .N_TERMS(4)) u0 (
        .clk(clk), .reset(reset), .resultado(resultado), .fin(fin),
        .clear(clear), .acc_out(acc_out), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .overflow(overflow), .perdido(perdido),
        .cuenta(cuenta)
    );

    acumulador_producto #(.PROD_W(6), .ACC_W(7), .N_TERMS(4)) u1 (
        .clk(clk), .reset(reset), .resultado(resultado), .fin(fin1),
        .clear(clear), .acc_out(acc_out1), .acc_valid(acc_valid1),
        .acc_ready(acc_ready), .overflow(overflow1), .perdido(perdido1),
        .cuenta(cuenta1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int v);
        resultado = 6'(v);
        fin = 1'b1;
        tick();
        fin = 1'b0;
        tick();
    endtask

    task automatic pulse1(input int v);
        resultado = 6'(v);
        fin1 = 1'b1;
        tick();
        fin1 = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; fin = 1'b0; fin1 = 1'b0; clear = 1'b0;
        acc_ready = 1'b0; resultado = '0;
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if ({acc_out, acc_valid, overflow, perdido, cuenta} !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_u0: got out=%h v=%b ov=%b p=%b c=%0d, want all 0",
                     acc_out, acc_valid, overflow, perdido, cuenta);
        end
        n_cmp++;
        if ({acc_out1, acc_valid1, overflow1, perdido1, cuenta1} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_u1: got out=%h v=%b ov=%b p=%b c=%0d, want all 0",
                     acc_out1, acc_valid1, overflow1, perdido1, cuenta1);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        acc_ready = 1'b0;
        q0.push_back({1'b0, 12'd7});
        pulse(6); pulse(-3);
        n_cmp++;
        if ({acc_valid, cuenta, acc_out} !== {1'b0, 3'd2, 12'd3}) begin
            n_bad++;
            $display("FAIL basic_partial: got v=%b c=%0d out=%h, want v=0 c=2 out=003",
                     acc_valid, cuenta, acc_out);
        end
        pulse(16); pulse(-12);
        e0 = q0.pop_front();
        n_cmp++;
        if ({acc_valid, overflow, acc_out, cuenta} !== {1'b1, e0, 3'd4}) begin
            n_bad++;
            $display("FAIL basic_group: got v=%b ov=%b out=%h c=%0d, want v=1 ov=%b out=%h c=4",
                     acc_valid, overflow, acc_out, cuenta, e0[12], e0[11:0]);
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        n_cmp++;
        if ({acc_valid, cuenta, acc_out} !== {1'b0, 3'd0, 12'd0}) begin
            n_bad++;
            $display("FAIL basic_taken: got v=%b c=%0d out=%h, want v=0 c=0 out=000",
                     acc_valid, cuenta, acc_out);
        end
    endtask

    task automatic test_fin_held();
        q0.push_back({1'b0, 12'd12});
        resultado = 6'd9;
        fin = 1'b1;
        repeat (5) tick();
        fin = 1'b0;
        tick();
        n_cmp++;
        if ({cuenta, acc_out} !== {3'd1, 12'd9}) begin
            n_bad++;
            $display("FAIL fin_held_once: got c=%0d out=%h, want c=1 out=009", cuenta, acc_out);
        end
        pulse(1); pulse(1); pulse(1);
        e0 = q0.pop_front();
        n_cmp++;
        if ({acc_valid, overflow, acc_out} !== {1'b1, e0}) begin
            n_bad++;
            $display("FAIL fin_held_group: got v=%b ov=%b out=%h, want v=1 ov=%b out=%h",
                     acc_valid, overflow, acc_out, e0[12], e0[11:0]);
        end
        pulse(1);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        n_cmp++;
        if ({acc_valid, cuenta, acc_out} !== {1'b0, 3'd1, 12'd1}) begin
            n_bad++;
            $display("FAIL fin_held_next: got v=%b c=%0d out=%h, want v=0 c=1 out=001",
                     acc_valid, cuenta, acc_out);
        end
        do_clear();
    endtask

    task automatic test_backpressure();
        q0.push_back({1'b0, 12'd10});
        pulse(1); pulse(2); pulse(3); pulse(4);
        e0 = q0.pop_front();
        n_cmp++;
        if ({acc_valid, overflow, acc_out} !== {1'b1, e0}) begin
            n_bad++;
            $display("FAIL bp_group: got v=%b ov=%b out=%h, want v=1 ov=%b out=%h",
                     acc_valid, overflow, acc_out, e0[12], e0[11:0]);
        end
        pulse(5); pulse(4);
        n_cmp++;
        if ({perdido, acc_valid, acc_out, cuenta} !== {1'b1, 1'b1, 12'd10, 3'd4}) begin
            n_bad++;
            $display("FAIL bp_drop: got p=%b v=%b out=%h c=%0d, want p=1 v=1 out=00a c=4",
                     perdido, acc_valid, acc_out, cuenta);
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        n_cmp++;
        if ({acc_valid, cuenta, acc_out, perdido} !== {1'b0, 3'd1, 12'd5, 1'b1}) begin
            n_bad++;
            $display("FAIL bp_release: got v=%b c=%0d out=%h p=%b, want v=0 c=1 out=005 p=1",
                     acc_valid, cuenta, acc_out, perdido);
        end
    endtask

    // Continues from the backpressure state: 5 already accumulated, perdido=1.
    task automatic test_clear();
        pulse(6);
        n_cmp++;
        if ({cuenta, acc_out} !== {3'd2, 12'd11}) begin
            n_bad++;
            $display("FAIL clear_pre: got c=%0d out=%h, want c=2 out=00b", cuenta, acc_out);
        end
        resultado = 6'd7;
        fin = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        fin = 1'b0;
        n_cmp++;
        if ({cuenta, acc_out, perdido, acc_valid} !== 17'd0) begin
            n_bad++;
            $display("FAIL clear_ev: got c=%0d out=%h p=%b v=%b, want all 0",
                     cuenta, acc_out, perdido, acc_valid);
        end
        tick();
        pulse(7);
        n_cmp++;
        if ({cuenta, acc_out} !== {3'd1, 12'd7}) begin
            n_bad++;
            $display("FAIL clear_after: got c=%0d out=%h, want c=1 out=007", cuenta, acc_out);
        end
        do_clear();
    endtask

    task automatic test_back_to_back();
        q0.push_back({1'b0, 12'd4});
        pulse(1); pulse(1); pulse(1); pulse(1);
        e0 = q0.pop_front();
        n_cmp++;
        if ({acc_valid, overflow, acc_out} !== {1'b1, e0}) begin
            n_bad++;
            $display("FAIL b2b_group: got v=%b ov=%b out=%h, want v=1 ov=%b out=%h",
                     acc_valid, overflow, acc_out, e0[12], e0[11:0]);
        end
        pulse(2);
        resultado = 6'd3;
        fin = 1'b1;
        acc_ready = 1'b1;
        tick();
        fin = 1'b0;
        acc_ready = 1'b0;
        n_cmp++;
        if ({acc_valid, cuenta, acc_out} !== {1'b0, 3'd2, 12'd5}) begin
            n_bad++;
            $display("FAIL b2b_seed: got v=%b c=%0d out=%h, want v=0 c=2 out=005",
                     acc_valid, cuenta, acc_out);
        end
        q0.push_back({1'b0, 12'hFFB});
        tick();
        pulse(10); pulse(-20);
        e0 = q0.pop_front();
        n_cmp++;
        if ({acc_valid, overflow, acc_out} !== {1'b1, e0}) begin
            n_bad++;
            $display("FAIL b2b_group2: got v=%b ov=%b out=%h, want v=1 ov=%b out=%h",
                     acc_valid, overflow, acc_out, e0[12], e0[11:0]);
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        do_clear();
    endtask

    task automatic test_overflow();
`ifdef ACUMULADOR_SATURA_EN
        q1.push_back({1'b1, 7'd62});
`else
        q1.push_back({1'b1, 7'h5C});
`endif
        pulse1(31); pulse1(31); pulse1(31);
        n_cmp++;
        if ({overflow1, cuenta1} !== {1'b1, 3'd3}) begin
            n_bad++;
            $display("FAIL ovf_flag: got ov=%b c=%0d, want ov=1 c=3", overflow1, cuenta1);
        end
        pulse1(-1);
        e1 = q1.pop_front();
        n_cmp++;
        if ({acc_valid1, overflow1, acc_out1} !== {1'b1, e1}) begin
            n_bad++;
            $display("FAIL ovf_group: got v=%b ov=%b out=%h, want v=1 ov=%b out=%h",
                     acc_valid1, overflow1, acc_out1, e1[7], e1[6:0]);
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        n_cmp++;
        if ({acc_valid1, overflow1, cuenta1, acc_out1} !== 12'd0) begin
            n_bad++;
            $display("FAIL ovf_taken: got v=%b ov=%b c=%0d out=%h, want all 0",
                     acc_valid1, overflow1, cuenta1, acc_out1);
        end
        q1.push_back({1'b0, 7'd4});
        pulse1(1); pulse1(1); pulse1(1); pulse1(1);
        e1 = q1.pop_front();
        n_cmp++;
        if ({acc_valid1, overflow1, acc_out1} !== {1'b1, e1}) begin
            n_bad++;
            $display("FAIL ovf_next_group: got v=%b ov=%b out=%h, want v=1 ov=%b out=%h",
                     acc_valid1, overflow1, acc_out1, e1[7], e1[6:0]);
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        pulse(3); pulse(4);
        pulse1(5);
        n_cmp++;
        if ({cuenta, acc_out, cuenta1, acc_out1} !== {3'd2, 12'd7, 3'd1, 7'd5}) begin
            n_bad++;
            $display("FAIL areset_pre: got c=%0d out=%h c1=%0d out1=%h, want 2/007/1/05",
                     cuenta, acc_out, cuenta1, acc_out1);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({acc_out, acc_valid, overflow, perdido, cuenta,
             acc_out1, acc_valid1, overflow1, perdido1, cuenta1} !== 31'd0) begin
            n_bad++;
            $display("FAIL areset_now: got out=%h c=%0d out1=%h c1=%0d, want all 0",
                     acc_out, cuenta, acc_out1, cuenta1);
        end
        #2 reset = 1'b1;
        tick();
        n_cmp++;
        if ({acc_out, cuenta, acc_valid} !== 16'd0) begin
            n_bad++;
            $display("FAIL areset_after: got out=%h c=%0d v=%b, want all 0",
                     acc_out, cuenta, acc_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fin_held();
        test_backpressure();
        test_clear();
        test_back_to_back();
        test_overflow();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acumulador_producto.md
Name: acumulador_producto

Overview:
- Downstream stage of the 3x3 Booth multiplier. It consumes each completed product (`resultado`, qualified by `fin`) and accumulates N_TERMS products into one signed sum (dot-product / MAC group).
- The finished sum is offered to the next stage through a valid/ready handshake.
- A 1-deep holding register absorbs a product that arrives while a sum is waiting to be taken.

Parameters:
- PROD_W, 6, width of incoming signed product (`resultado`)
- ACC_W, 12, accumulator and output width; must satisfy ACC_W >= PROD_W
- N_TERMS, 4, products per group; must satisfy N_TERMS >= 2

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous reset, active-low (reset=0 resets)
- resultado  in  PROD_W  signed two's-complement product from the multiplier
- fin  in  1  multiplier done; may stay high several cycles
- clear  in  1  synchronous flush of group, holding register and flags
- acc_out  out  ACC_W  signed group sum
- acc_valid  out  1  acc_out holds a completed group
- acc_ready  in  1  consumer accepts acc_out
- overflow  out  1  signed overflow occurred in the group now on acc_out
- perdido  out  1  sticky: a product was dropped
- cuenta  out  $clog2(N_TERMS+1)  products in the current group

Behaviour:
- Reset (reset=0, async):
  - acc=0, acc_out=0, acc_valid=0, overflow=0, perdido=0, cuenta=0.
  - Holding register empty, fin_q=0, state ACUM.
- Event detection:
  - fin_q registers fin. An event ev = fin & ~fin_q (rising edge only).
  - fin held high counts once. A fin already high when reset deasserts counts once on the first edge seen.
- Product handling: p = sign-extend(resultado) to ACC_W, sampled in the ev cycle.
- Addition:
  - ACC_W-bit two's complement, wraps.
  - Overflow = operands share a sign and the sum's sign differs. Overflow is ORed into the group's flag.
- State ACUM:
  - On ev: acc += p, cuenta += 1, overflow flag updated.
  - If cuenta reaches N_TERMS in that update: next state ENTREGA, acc_valid=1 from the next cycle.
  - acc_out mirrors acc.
- State ENTREGA:
  - acc_valid=1; acc_out and overflow are held stable until the handshake.
  - ev without handshake, holding register empty: p is stored.
  - ev without handshake, holding register full: p is discarded and perdido=1 (sticky).
  - Handshake (acc_valid & acc_ready): the new group starts as acc = sum of held p (if any) and current-cycle p (if ev).
    - cuenta = number of those terms (0..2); overflow recomputed for that sum; holding register emptied.
    - Next state ACUM, unless cuenta already equals N_TERMS, in which case stay in ENTREGA with the new sum.
    - acc_valid drops for at least one cycle only when the next state is ACUM.
- clear=1 has priority over ev and the handshake in the same cycle:
  - acc=0, cuenta=0, holding register empty, overflow=0, perdido=0, acc_valid=0.
  - State ACUM, fin_q still updated.
- Latency: ev at cycle t is reflected in acc_out/cuenta at t+1. The Nth ev at t gives acc_valid=1 at t+1.
- Reset mid-group discards all partial state immediately.

Optional Feature:
- Macro ACUMULADOR_SATURA_EN.
- Defined:
  - On signed overflow, acc clamps to +2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow) instead of wrapping.
  - overflow still asserts.
  - Later additions start from the clamped value.
- Undefined: wrap-around arithmetic as above.

Test Plan:
- Basic group (defaults): products 6, -3, 16, -12, each a 1-cycle fin pulse → acc_valid=1 with acc_out=7 (0x007), overflow=0; acc_ready=1 → acc_valid=0 next cycle, cuenta=0.
- Fin held high 5 cycles with resultado=9, then low, then four 1-cycle pulses of 1 → exactly 5 events counted; first group sum = 9+1+1+1 = 12 and cuenta shows 1 at the next group start.
- Backpressure (acc_ready=0): complete group, then two further events 5 and 4 → 5 held, 4 dropped, perdido=1, acc_out unchanged; raise acc_ready → new acc_out=5, cuenta=1.
- Simultaneous handshake and event: group valid, holding register holds 2, ev with 3 in the handshake cycle → next cycle acc_out=5, cuenta=2, state ACUM.
- Overflow, ACC_W=7: products 31, 31, 31, -1 → without macro acc_out=-36 (7'h5C), overflow=1; with ACUMULADOR_SATURA_EN acc_out=62 (63 saturated, then -1), overflow=1.
- clear and reset: clear asserted in the same cycle as the 3rd ev → cuenta=0, acc_out=0, perdido=0. Async reset=0 mid-group, no clk edge → all outputs 0 immediately.
